// File: rtl/lifo_stack_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
// Op encoding mirrors the {push,pop} input pair so decode is a plain cast.
package lifo_stack_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({push, pop});
  endfunction

endpackage

// File: rtl/lifo_stack_ctrl.sv
// Stack controller: op decode, occupancy count, flags and error pulses.
// Optional high-water tracking is enabled with LIFO_STACK_WATERMARK_EN.
module lifo_stack_ctrl
  import lifo_stack_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = cnt_width(DEPTH),
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
`ifdef LIFO_STACK_WATERMARK_EN
  input  logic             hw_clr,
  output logic [CNT_W-1:0] high_water,
`endif
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [IDX_W-1:0] rd_idx
);

  op_e              op;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [IDX_W-1:0] top_idx;

  assign op      = decode_op(push, pop);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign top_idx = IDX_W'(count_q - CNT_W'(1));

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = IDX_W'(count_q);
    case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (empty) unf_d = 1'b1;
        else       count_d = count_q - CNT_W'(1);
      end
      OP_REPL: begin
        // Replace-top on an empty stack degenerates into a plain push.
        wr_en = 1'b1;
        if (empty) count_d = count_q + CNT_W'(1);
        else       wr_idx  = top_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef LIFO_STACK_WATERMARK_EN
  logic [CNT_W-1:0] hw_q, hw_d;

  // A clear re-arms the mark at the post-edge occupancy, not at zero.
  always_comb begin
    hw_d = hw_q;
    if (hw_clr)              hw_d = count_d;
    else if (count_d > hw_q) hw_d = count_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hw_q <= '0;
    else        hw_q <= hw_d;
  end

  assign high_water = hw_q;
`endif

  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign rd_idx    = top_idx;

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack top: register-array storage plus zero-latency top read.
// push/pop are single-cycle strobes sampled every rising edge with no backpressure;
// a rejected op is reported by an overflow/underflow pulse on the following cycle.
// Optional high-water mark ports are enabled with LIFO_STACK_WATERMARK_EN.
module lifo_stack_param
  import lifo_stack_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
`ifdef LIFO_STACK_WATERMARK_EN
  input  logic              hw_clr,
  output logic [CNT_W-1:0]  high_water,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int IDX_W = $clog2(DEPTH);

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  lifo_stack_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
`ifdef LIFO_STACK_WATERMARK_EN
    .hw_clr     (hw_clr),
    .high_water (high_water),
`endif
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .rd_idx     (rd_idx)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = data_in;
  end

  // Storage is deliberately left out of reset; only count defines validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign data_out = empty ? '0 : mem_q[rd_idx];

endmodule

// File: tb/tb_lifo_stack_param.sv
// Self-checking bench for lifo_stack_param (DATA_W=8, DEPTH=4) against a queue model.
// Build with LIFO_STACK_WATERMARK_EN defined to also cover the high-water mark.
module tb_lifo_stack_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk     = 1'b0;
  logic              reset   = 1'b0;
  logic              push    = 1'b0;
  logic              pop     = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  count;
  logic              empty, full, overflow, underflow;
`ifdef LIFO_STACK_WATERMARK_EN
  logic              hw_clr = 1'b0;
  logic [CNT_W-1:0]  high_water;
`endif

  lifo_stack_param #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .data_in    (data_in),
`ifdef LIFO_STACK_WATERMARK_EN
    .hw_clr     (hw_clr),
    .high_water (high_water),
`endif
    .data_out   (data_out),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_ovf = 1'b0;
  logic              exp_unf = 1'b0;
  int                exp_hw  = 0;
  int                n_checks = 0;
  int                n_errors = 0;

  function automatic logic [DATA_W-1:0] exp_top();
    if (exp_q.size() == 0) return '0;
    return exp_q[exp_q.size()-1];
  endfunction

  // {count, empty, full, overflow, underflow}
  function automatic logic [CNT_W+3:0] exp_status();
    return {CNT_W'(exp_q.size()), exp_q.size() == 0, exp_q.size() == DEPTH, exp_ovf, exp_unf};
  endfunction

  // driver: one clock of stimulus, then advance the model
  task automatic step(input logic p, input logic q, input logic [DATA_W-1:0] d, input logic c);
    @(negedge clk);
    push = p; pop = q; data_in = d;
`ifdef LIFO_STACK_WATERMARK_EN
    hw_clr = c;
`endif
    @(posedge clk);
    #1;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    if (p && !q) begin
      if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(d);
    end else if (!p && q) begin
      if (exp_q.size() == 0) exp_unf = 1'b1;
      else void'(exp_q.pop_back());
    end else if (p && q) begin
      if (exp_q.size() == 0) exp_q.push_back(d);
      else exp_q[exp_q.size()-1] = d;
    end
    if (c) exp_hw = exp_q.size();
    else if (exp_q.size() > exp_hw) exp_hw = exp_q.size();
    push = 1'b0; pop = 1'b0;
`ifdef LIFO_STACK_WATERMARK_EN
    hw_clr = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({count, empty, full, overflow, underflow} !== 7'b000_1_0_0_0) begin
      n_errors++;
      $display("FAIL reset_status: got %b expected %b", {count, empty, full, overflow, underflow}, 7'b000_1_0_0_0);
    end
    n_checks++;
    if (data_out !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_data: got %h expected 00", data_out);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      n_checks++;
      if ({count, empty, full, overflow, underflow} !== exp_status()) begin
        n_errors++;
        $display("FAIL idle_status: got %b expected %b", {count, empty, full, overflow, underflow}, exp_status());
      end
      n_checks++;
      if (data_out !== exp_top()) begin
        n_errors++;
        $display("FAIL idle_data: got %h expected %h", data_out, exp_top());
      end
    end
  endtask

  task automatic test_push_fill();
    logic [DATA_W-1:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, vals[i], 1'b0);
      n_checks++;
      if ({count, empty, full, overflow, underflow} !== exp_status()) begin
        n_errors++;
        $display("FAIL push_status[%0d]: got %b expected %b", i, {count, empty, full, overflow, underflow}, exp_status());
      end
      n_checks++;
      if (data_out !== exp_top()) begin
        n_errors++;
        $display("FAIL push_data[%0d]: got %h expected %h", i, data_out, exp_top());
      end
    end
    n_checks++;
    if (overflow !== 1'b1 || count !== 3'd4 || full !== 1'b1 || data_out !== 8'h44) begin
      n_errors++;
      $display("FAIL overflow_hit: got ovf=%b cnt=%0d full=%b data=%h expected ovf=1 cnt=4 full=1 data=44",
               overflow, count, full, data_out);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (overflow !== 1'b0 || count !== 3'd4) begin
      n_errors++;
      $display("FAIL overflow_pulse: got ovf=%b cnt=%0d expected ovf=0 cnt=4", overflow, count);
    end
  endtask

  task automatic test_pop_drain();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      n_checks++;
      if ({count, empty, full, overflow, underflow} !== exp_status()) begin
        n_errors++;
        $display("FAIL pop_status[%0d]: got %b expected %b", i, {count, empty, full, overflow, underflow}, exp_status());
      end
      n_checks++;
      if (data_out !== exp_top()) begin
        n_errors++;
        $display("FAIL pop_data[%0d]: got %h expected %h", i, data_out, exp_top());
      end
    end
    n_checks++;
    if (underflow !== 1'b1 || count !== 3'd0 || empty !== 1'b1 || data_out !== 8'h00) begin
      n_errors++;
      $display("FAIL underflow_hit: got unf=%b cnt=%0d empty=%b data=%h expected unf=1 cnt=0 empty=1 data=00",
               underflow, count, empty, data_out);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL underflow_pulse: got %b expected 0", underflow);
    end
  endtask

  task automatic test_replace();
    step(1'b1, 1'b0, 8'hA0, 1'b0);
    step(1'b1, 1'b1, 8'hB0, 1'b0);
    n_checks++;
    if (count !== 3'd1 || data_out !== 8'hB0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL replace_top: got cnt=%0d data=%h ovf=%b unf=%b expected cnt=1 data=b0 ovf=0 unf=0",
               count, data_out, overflow, underflow);
    end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'hC0, 1'b0);
    n_checks++;
    if (count !== 3'd1 || data_out !== 8'hC0 || underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL replace_empty: got cnt=%0d data=%h unf=%b expected cnt=1 data=c0 unf=0",
               count, data_out, underflow);
    end
    n_checks++;
    if ({count, empty, full, overflow, underflow} !== exp_status() || data_out !== exp_top()) begin
      n_errors++;
      $display("FAIL replace_model: got %b/%h expected %b/%h", {count, empty, full, overflow, underflow},
               data_out, exp_status(), exp_top());
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    exp_hw  = 0;
    n_checks++;
    if (count !== 3'd0 || empty !== 1'b1 || data_out !== 8'h00) begin
      n_errors++;
      $display("FAIL async_reset: got cnt=%0d empty=%b data=%h expected cnt=0 empty=1 data=00",
               count, empty, data_out);
    end
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 8'h03, 1'b0);
    n_checks++;
    if (count !== 3'd1 || data_out !== 8'h03) begin
      n_errors++;
      $display("FAIL post_reset_push: got cnt=%0d data=%h expected cnt=1 data=03", count, data_out);
    end
  endtask

`ifdef LIFO_STACK_WATERMARK_EN
  task automatic test_watermark();
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (high_water !== 3'd0) begin
      n_errors++;
      $display("FAIL hw_clr_empty: got %0d expected 0", high_water);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    n_checks++;
    if (high_water !== 3'd3) begin
      n_errors++;
      $display("FAIL hw_peak: got %0d expected 3", high_water);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if (high_water !== 3'd1) begin
      n_errors++;
      $display("FAIL hw_clr: got %0d expected 1", high_water);
    end
    step(1'b1, 1'b0, 8'h5A, 1'b0);
    n_checks++;
    if (high_water !== 3'd2) begin
      n_errors++;
      $display("FAIL hw_rise: got %0d expected 2", high_water);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           $urandom_range(0, 15) == 0);
      n_checks++;
      if ({count, empty, full, overflow, underflow} !== exp_status()) begin
        n_errors++;
        $display("FAIL rand_status[%0d]: got %b expected %b", i, {count, empty, full, overflow, underflow}, exp_status());
      end
      n_checks++;
      if (data_out !== exp_top()) begin
        n_errors++;
        $display("FAIL rand_data[%0d]: got %h expected %h", i, data_out, exp_top());
      end
`ifdef LIFO_STACK_WATERMARK_EN
      n_checks++;
      if (high_water !== CNT_W'(exp_hw)) begin
        n_errors++;
        $display("FAIL rand_hw[%0d]: got %0d expected %0d", i, high_water, exp_hw);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_push_fill();
    test_pop_drain();
    test_replace();
    test_async_reset();
`ifdef LIFO_STACK_WATERMARK_EN
    test_watermark();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
